// File: rtl/riscv_ctrl_pkg.sv
// Shared definitions for the multicycle RV32I control unit.
//   - opcode constants for the supported instruction classes
//   - ALUOp codes and datapath mux select encodings
//   - 4-bit main FSM state enumeration
//   - instruction-class one-hot used by DECODE for branching
package riscv_ctrl_pkg;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCA_PC     = 2'b00;
    localparam logic [1:0] SRCA_OLDPC  = 2'b01;
    localparam logic [1:0] SRCA_RD1    = 2'b10;

    localparam logic [1:0] SRCB_RD2    = 2'b00;
    localparam logic [1:0] SRCB_IMM    = 2'b01;
    localparam logic [1:0] SRCB_FOUR   = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10
    } state_t;

    typedef struct packed {
        logic lw;
        logic sw;
        logic r;
        logic i;
        logic beq;
        logic jal;
        logic illegal;
    } inst_class_t;

endpackage

// File: rtl/riscv_imm_src_dec.sv
// Opcode decoder for the control unit.
//   i_op      : instruction opcode from IR
//   o_imm_src : immediate format select (I/S/B/J)
//   o_cls     : one-hot instruction class, exactly one bit set
module riscv_imm_src_dec
    import riscv_ctrl_pkg::*;
(
    input  logic [6:0]  i_op,
    output logic [1:0]  o_imm_src,
    output inst_class_t o_cls
);

    always_comb begin
        o_imm_src = IMM_I;
        o_cls     = '0;
        case (i_op)
            OP_LW:   o_cls.lw = 1'b1;
            OP_I:    o_cls.i  = 1'b1;
            OP_R:    o_cls.r  = 1'b1;
            OP_SW: begin
                o_cls.sw  = 1'b1;
                o_imm_src = IMM_S;
            end
            OP_BEQ: begin
                o_cls.beq = 1'b1;
                o_imm_src = IMM_B;
            end
            OP_JAL: begin
                o_cls.jal = 1'b1;
                o_imm_src = IMM_J;
            end
            default: o_cls.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/riscv_mc_controller.sv
// Main control FSM for the multicycle RV32I datapath.
//   i_clk, i_rst_n : clock and asynchronous active-low reset
//   i_op           : opcode from IR
//   i_zero         : ALU zero flag (beq resolution)
//   i_mem_ready    : memory completes the current access this cycle
//   o_ALUOp        : ALU decoder control (ADD / SUB / funct)
//   o_ALUSrcA/B    : ALU operand selects
//   o_ResultSrc    : result mux select
//   o_ImmSrc       : immediate format, decoded from i_op
//   o_AdrSrc       : memory address select
//   o_IRWrite, o_PCWrite, o_RegWrite, o_MemWrite : write enables
//   o_illegal      : one-cycle pulse on an unsupported opcode in DECODE
//
// state    | meaning
// FETCH    | read instruction at PC, PC+4 into PC when memory ready
// DECODE   | read registers, branch target into ALUOut
// MEMADR   | compute load/store address
// MEMREAD  | load access, wait for ready
// MEMWB    | write loaded data to register file
// MEMWRITE | store access, wait for ready
// EXECR    | register-register ALU op
// EXECI    | register-immediate ALU op
// ALUWB    | write ALUOut to register file
// BEQ      | compare, take branch on zero
// JAL      | PC <- target, return address computed
module riscv_mc_controller
    import riscv_ctrl_pkg::*;
#(
    parameter bit RESET_PC_UPDATE = 1'b0
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [6:0] i_op,
    input  logic       i_zero,
    input  logic       i_mem_ready,
    output logic [1:0] o_ALUOp,
    output logic [1:0] o_ALUSrcA,
    output logic [1:0] o_ALUSrcB,
    output logic [1:0] o_ResultSrc,
    output logic [1:0] o_ImmSrc,
    output logic       o_AdrSrc,
    output logic       o_IRWrite,
    output logic       o_PCWrite,
    output logic       o_RegWrite,
    output logic       o_MemWrite,
    output logic       o_illegal
);

    state_t      state_q, state_d;
    inst_class_t cls;

    logic ir_write, pc_update, branch, reg_write, mem_write, illegal;
    logic we_allow;

    riscv_imm_src_dec u_dec (
        .i_op      (i_op),
        .o_imm_src (o_ImmSrc),
        .o_cls     (cls)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state_q <= S_FETCH;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        o_ALUOp     = ALUOP_ADD;
        o_ALUSrcA   = SRCA_PC;
        o_ALUSrcB   = SRCB_RD2;
        o_ResultSrc = RES_ALUOUT;
        o_AdrSrc    = 1'b0;
        ir_write    = 1'b0;
        pc_update   = 1'b0;
        branch      = 1'b0;
        reg_write   = 1'b0;
        mem_write   = 1'b0;
        illegal     = 1'b0;
        case (state_q)
            S_FETCH: begin
                o_ALUSrcB   = SRCB_FOUR;
                o_ResultSrc = RES_ALURESULT;
                ir_write    = i_mem_ready;
                pc_update   = i_mem_ready;
                if (i_mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                o_ALUSrcA = SRCA_OLDPC;
                o_ALUSrcB = SRCB_IMM;
                if (cls.lw || cls.sw) state_d = S_MEMADR;
                else if (cls.r)       state_d = S_EXECR;
                else if (cls.i)       state_d = S_EXECI;
                else if (cls.beq)     state_d = S_BEQ;
                else if (cls.jal)     state_d = S_JAL;
                else begin
                    illegal = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_MEMADR: begin
                o_ALUSrcA = SRCA_RD1;
                o_ALUSrcB = SRCB_IMM;
                // IR is stable here, so anything but a store is treated as a load
                state_d   = cls.sw ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                o_AdrSrc = 1'b1;
                if (i_mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                o_ResultSrc = RES_DATA;
                reg_write   = 1'b1;
                state_d     = S_FETCH;
            end
            S_MEMWRITE: begin
                o_AdrSrc  = 1'b1;
                mem_write = 1'b1;
                if (i_mem_ready) state_d = S_FETCH;
            end
            S_EXECR: begin
                o_ALUSrcA = SRCA_RD1;
                o_ALUOp   = ALUOP_FUNCT;
                state_d   = S_ALUWB;
            end
            S_EXECI: begin
                o_ALUSrcA = SRCA_RD1;
                o_ALUSrcB = SRCB_IMM;
                o_ALUOp   = ALUOP_FUNCT;
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                state_d   = S_FETCH;
            end
            S_BEQ: begin
                o_ALUSrcA = SRCA_RD1;
                o_ALUOp   = ALUOP_SUB;
                branch    = 1'b1;
                state_d   = S_FETCH;
            end
            S_JAL: begin
                o_ALUSrcA = SRCA_OLDPC;
                o_ALUSrcB = SRCB_FOUR;
                pc_update = 1'b1;
                state_d   = S_ALUWB;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Reset forces FETCH asynchronously, and FETCH would otherwise raise
    // IRWrite/PCWrite from i_mem_ready, so enables are masked by reset itself.
    assign we_allow   = RESET_PC_UPDATE ? 1'b1 : i_rst_n;

    assign o_IRWrite  = ir_write  & we_allow;
    assign o_PCWrite  = ((branch & i_zero) | pc_update) & we_allow;
    assign o_RegWrite = reg_write & we_allow;
    assign o_MemWrite = mem_write & we_allow;
    assign o_illegal  = illegal   & i_rst_n;

endmodule

// File: tb/tb_riscv_mc_controller.sv
// Directed bench for riscv_mc_controller. Outputs are packed into one
// 16-bit vector {ALUOp,SrcA,SrcB,ResultSrc,ImmSrc,AdrSrc,IRWrite,PCWrite,
// RegWrite,MemWrite,illegal} and compared against hand-built expectations.
module tb_riscv_mc_controller;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] op;
    logic       zero;
    logic       ready;

    logic [1:0] alu_op, src_a, src_b, res_src, imm_src;
    logic       adr_src, ir_w, pc_w, reg_w, mem_w, ill;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    riscv_mc_controller dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_op        (op),
        .i_zero      (zero),
        .i_mem_ready (ready),
        .o_ALUOp     (alu_op),
        .o_ALUSrcA   (src_a),
        .o_ALUSrcB   (src_b),
        .o_ResultSrc (res_src),
        .o_ImmSrc    (imm_src),
        .o_AdrSrc    (adr_src),
        .o_IRWrite   (ir_w),
        .o_PCWrite   (pc_w),
        .o_RegWrite  (reg_w),
        .o_MemWrite  (mem_w),
        .o_illegal   (ill)
    );

    logic [15:0] obs;
    assign obs = {alu_op, src_a, src_b, res_src, imm_src, adr_src, ir_w, pc_w, reg_w, mem_w, ill};

    // Per-state static outputs: ALUOp SrcA SrcB ResSrc Imm Adr IRW PCW RW MW ILL
    localparam logic [15:0] E_FETCH    = {2'b00, 2'b00, 2'b10, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam logic [15:0] E_DECODE   = {2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam logic [15:0] E_MEMADR   = {2'b00, 2'b10, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam logic [15:0] E_MEMREAD  = {2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam logic [15:0] E_MEMWB    = {2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    localparam logic [15:0] E_MEMWRITE = {2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    localparam logic [15:0] E_EXECR    = {2'b10, 2'b10, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam logic [15:0] E_EXECI    = {2'b10, 2'b10, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam logic [15:0] E_ALUWB    = {2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    localparam logic [15:0] E_BEQ      = {2'b01, 2'b10, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam logic [15:0] E_JAL      = {2'b00, 2'b01, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    // Adds the op-dependent ImmSrc and the dynamic IRWrite/PCWrite/illegal bits.
    function automatic logic [15:0] mk(input logic [15:0] base, input logic [1:0] imm,
                                       input logic irw, input logic pcw, input logic il);
        return base | {8'b0, imm, 1'b0, irw, pcw, 1'b0, 1'b0, il};
    endfunction

    task automatic chk(input string tag, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        op    = 7'b0110011;
        zero  = 1'b0;
        ready = 1'b1;
        #3;
        chk("reset_gated", mk(E_FETCH, 2'b00, 1'b0, 1'b0, 1'b0));
        #9;
        rst_n = 1'b1;
        #1;
        // R-type
        chk("r_fetch",  mk(E_FETCH,  2'b00, 1'b1, 1'b1, 1'b0));
        step(); chk("r_decode", mk(E_DECODE, 2'b00, 1'b0, 1'b0, 1'b0));
        step(); chk("r_execr",  mk(E_EXECR,  2'b00, 1'b0, 1'b0, 1'b0));
        step(); chk("r_aluwb",  mk(E_ALUWB,  2'b00, 1'b0, 1'b0, 1'b0));
        step();
        // lw with two not-ready cycles in MEMREAD
        op = 7'b0000011; #1;
        chk("lw_fetch",  mk(E_FETCH,  2'b00, 1'b1, 1'b1, 1'b0));
        step(); chk("lw_decode", mk(E_DECODE, 2'b00, 1'b0, 1'b0, 1'b0));
        step(); chk("lw_memadr", mk(E_MEMADR, 2'b00, 1'b0, 1'b0, 1'b0));
        step(); ready = 1'b0; #1;
        chk("lw_memread0", mk(E_MEMREAD, 2'b00, 1'b0, 1'b0, 1'b0));
        step(); chk("lw_memread1", mk(E_MEMREAD, 2'b00, 1'b0, 1'b0, 1'b0));
        step(); chk("lw_memread2", mk(E_MEMREAD, 2'b00, 1'b0, 1'b0, 1'b0));
        ready = 1'b1;
        step(); chk("lw_memwb", mk(E_MEMWB, 2'b00, 1'b0, 1'b0, 1'b0));
        step();
        // sw
        op = 7'b0100011; #1;
        chk("sw_fetch",  mk(E_FETCH,    2'b01, 1'b1, 1'b1, 1'b0));
        step(); chk("sw_decode", mk(E_DECODE,   2'b01, 1'b0, 1'b0, 1'b0));
        step(); chk("sw_memadr", mk(E_MEMADR,   2'b01, 1'b0, 1'b0, 1'b0));
        step(); chk("sw_memwr",  mk(E_MEMWRITE, 2'b01, 1'b0, 1'b0, 1'b0));
        step();
        // beq taken
        op = 7'b1100011; #1;
        chk("beqt_fetch",  mk(E_FETCH,  2'b10, 1'b1, 1'b1, 1'b0));
        step(); chk("beqt_decode", mk(E_DECODE, 2'b10, 1'b0, 1'b0, 1'b0));
        step(); zero = 1'b1; #1;
        chk("beqt_beq", mk(E_BEQ, 2'b10, 1'b0, 1'b1, 1'b0));
        step(); zero = 1'b0;
        // beq not taken
        chk("beqn_fetch",  mk(E_FETCH,  2'b10, 1'b1, 1'b1, 1'b0));
        step(); chk("beqn_decode", mk(E_DECODE, 2'b10, 1'b0, 1'b0, 1'b0));
        step(); chk("beqn_beq",    mk(E_BEQ,    2'b10, 1'b0, 1'b0, 1'b0));
        step();
        // jal
        op = 7'b1101111; #1;
        chk("jal_fetch",  mk(E_FETCH,  2'b11, 1'b1, 1'b1, 1'b0));
        step(); chk("jal_decode", mk(E_DECODE, 2'b11, 1'b0, 1'b0, 1'b0));
        step(); chk("jal_jal",    mk(E_JAL,    2'b11, 1'b0, 1'b1, 1'b0));
        step(); chk("jal_aluwb",  mk(E_ALUWB,  2'b11, 1'b0, 1'b0, 1'b0));
        step();
        // I-ALU
        op = 7'b0010011; #1;
        chk("i_fetch",  mk(E_FETCH,  2'b00, 1'b1, 1'b1, 1'b0));
        step(); chk("i_decode", mk(E_DECODE, 2'b00, 1'b0, 1'b0, 1'b0));
        step(); chk("i_execi",  mk(E_EXECI,  2'b00, 1'b0, 1'b0, 1'b0));
        step(); chk("i_aluwb",  mk(E_ALUWB,  2'b00, 1'b0, 1'b0, 1'b0));
        step();
        // fetch stall, then illegal opcode
        op = 7'b1111111; ready = 1'b0; #1;
        chk("stall_fetch0", mk(E_FETCH, 2'b00, 1'b0, 1'b0, 1'b0));
        step(); chk("stall_fetch1", mk(E_FETCH, 2'b00, 1'b0, 1'b0, 1'b0));
        ready = 1'b1; #1;
        chk("ill_fetch",  mk(E_FETCH,  2'b00, 1'b1, 1'b1, 1'b0));
        step(); chk("ill_decode", mk(E_DECODE, 2'b00, 1'b0, 1'b0, 1'b1));
        step(); chk("ill_after",  mk(E_FETCH,  2'b00, 1'b1, 1'b1, 1'b0));
        // sw aborted by reset while waiting in MEMWRITE
        op = 7'b0100011; #1;
        step(); chk("rs_decode", mk(E_DECODE, 2'b01, 1'b0, 1'b0, 1'b0));
        step(); chk("rs_memadr", mk(E_MEMADR, 2'b01, 1'b0, 1'b0, 1'b0));
        step(); ready = 1'b0; #1;
        chk("rs_memwr0", mk(E_MEMWRITE, 2'b01, 1'b0, 1'b0, 1'b0));
        step(); chk("rs_memwr1", mk(E_MEMWRITE, 2'b01, 1'b0, 1'b0, 1'b0));
        #2; rst_n = 1'b0; #1;
        chk("rs_async_drop", mk(E_FETCH, 2'b01, 1'b0, 1'b0, 1'b0));
        ready = 1'b1;
        step(); chk("rs_held", mk(E_FETCH, 2'b01, 1'b0, 1'b0, 1'b0));
        #2; ready = 1'b0; rst_n = 1'b1; #1;
        chk("rs_rel_notready", mk(E_FETCH, 2'b01, 1'b0, 1'b0, 1'b0));
        ready = 1'b1; #1;
        chk("rs_rel_ready", mk(E_FETCH, 2'b01, 1'b1, 1'b1, 1'b0));
        step(); chk("rs_decode2", mk(E_DECODE, 2'b01, 1'b0, 1'b0, 1'b0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
